// File: rtl/input_conditioner.sv
// Button/switch front end: synchroniser, tick-based debounce, edge
// detection and per-channel hold-to-repeat on one shared timebase.
module input_conditioner #(
   parameter int CH               = 21,
   parameter int TICK_DIV         = 100000,
   parameter int DB_TICKS         = 10,
   parameter int RPT_DELAY_TICKS  = 500,
   parameter int RPT_PERIOD_TICKS = 100
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] in,
   input  logic [CH-1:0] rpt_en,
   output logic [CH-1:0] level,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] press,
   output logic          any_press
);

   localparam int TW   = $clog2(TICK_DIV);
   localparam int DW   = $clog2(DB_TICKS + 1);
   localparam int RMAX = (RPT_DELAY_TICKS > RPT_PERIOD_TICKS) ?
                         RPT_DELAY_TICKS : RPT_PERIOD_TICKS;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TONE  = TW'(1);
   localparam logic [DW-1:0] DLAST = DW'(DB_TICKS - 1);
   localparam logic [DW-1:0] DONE  = DW'(1);
   localparam logic [RW-1:0] RDLY  = RW'(RPT_DELAY_TICKS - 1);
   localparam logic [RW-1:0] RPER  = RW'(RPT_PERIOD_TICKS - 1);
   localparam logic [RW-1:0] RONE  = RW'(1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rstate_e;

   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          tick;
   logic [CH-1:0] s1_q, s_q;
   logic [CH-1:0] level_q, level_d;
   logic [CH-1:0] rise_q, rise_d;
   logic [CH-1:0] fall_q, fall_d;
   logic [CH-1:0] press_q, press_d;
   logic [CH-1:0] hit;
   logic          any_q;
   logic [DW-1:0] dcnt_q [CH];
   logic [DW-1:0] dcnt_d [CH];
   logic [RW-1:0] rcnt_q [CH];
   logic [RW-1:0] rcnt_d [CH];
   rstate_e       st_q   [CH];
   rstate_e       st_d   [CH];

   assign tick = (tcnt_q == TLAST);

   always_comb begin
      tcnt_d  = tick ? '0 : tcnt_q + TONE;
      level_d = level_q;
      dcnt_d  = dcnt_q;
      rise_d  = '0;
      fall_d  = '0;
      hit     = '0;
      st_d    = st_q;
      rcnt_d  = rcnt_q;
      for (int i = 0; i < CH; i++) begin
         if (s_q[i] == level_q[i]) begin
            dcnt_d[i] = '0;
         end else if (tick) begin
            if (dcnt_q[i] == DLAST) begin
               level_d[i] = s_q[i];
               dcnt_d[i]  = '0;
               rise_d[i]  = s_q[i];
               fall_d[i]  = ~s_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DONE;
            end
         end
         // a falling level this edge also cancels a coincident repeat
         unique case (st_q[i])
            IDLE: begin
               if (rise_q[i] && rpt_en[i]) begin
                  st_d[i]   = DELAY;
                  rcnt_d[i] = '0;
               end
            end
            DELAY: begin
               if (!level_q[i] || !rpt_en[i] || fall_d[i]) begin
                  st_d[i] = IDLE;
               end else if (tick) begin
                  if (rcnt_q[i] == RDLY) begin
                     hit[i]    = 1'b1;
                     rcnt_d[i] = '0;
                     st_d[i]   = REPEAT;
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + RONE;
                  end
               end
            end
            REPEAT: begin
               if (!level_q[i] || !rpt_en[i] || fall_d[i]) begin
                  st_d[i] = IDLE;
               end else if (tick) begin
                  if (rcnt_q[i] == RPER) begin
                     hit[i]    = 1'b1;
                     rcnt_d[i] = '0;
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + RONE;
                  end
               end
            end
            default: st_d[i] = IDLE;
         endcase
      end
      press_d = rise_d | hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q  <= '0;
         s1_q    <= '0;
         s_q     <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         press_q <= '0;
         any_q   <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            dcnt_q[i] <= '0;
            rcnt_q[i] <= '0;
            st_q[i]   <= IDLE;
         end
      end else begin
         tcnt_q  <= tcnt_d;
         s1_q    <= in;
         s_q     <= s1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         press_q <= press_d;
         any_q   <= |press_q;
         dcnt_q  <= dcnt_d;
         rcnt_q  <= rcnt_d;
         st_q    <= st_d;
      end
   end

   assign level     = level_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign press     = press_q;
   assign any_press = any_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a scoreboard queue of expected
// rise/fall/press events, each with a cycle window, checked on negedge.
module tb_input_conditioner;

   logic       clk;
   logic       rst;
   logic [2:0] din;
   logic [2:0] ren;
   logic [2:0] lvl;
   logic [2:0] rs;
   logic [2:0] fl;
   logic [2:0] pr;
   logic       anyp;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_rise [3] = '{-1, -1, -1};
   bit prev_any = 1'b0;

   typedef struct {
      logic [2:0] rise;
      logic [2:0] fall;
      logic [2:0] press;
      int         lo;
      int         hi;
      int         rch;
   } exp_t;

   exp_t expq [$];

   input_conditioner #(
      .CH              (3),
      .TICK_DIV        (4),
      .DB_TICKS        (3),
      .RPT_DELAY_TICKS (5),
      .RPT_PERIOD_TICKS(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (din),
      .rpt_en   (ren),
      .level    (lvl),
      .rise     (rs),
      .fall     (fl),
      .press    (pr),
      .any_press(anyp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input logic [2:0] r, input logic [2:0] f,
                       input logic [2:0] p, input int lo, input int hi,
                       input int rch);
      exp_t e;
      e.rise  = r;
      e.fall  = f;
      e.press = p;
      e.lo    = lo;
      e.hi    = hi;
      e.rch   = rch;
      expq.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int max, input string tag);
      int n = 0;
      while (expq.size() != 0 && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      assert (expq.size() == 0) else begin
         errors++;
         $error("FAIL drain_%s: %0d events outstanding, expected 0",
                tag, expq.size());
      end
      expq.delete();
   endtask

   task automatic wait_rise(input int ch, input int old, output int r);
      int n = 0;
      while (last_rise[ch] == old && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      assert (last_rise[ch] != old) else begin
         errors++;
         $error("FAIL rise_wait ch%0d: got no rise, expected one", ch);
      end
      r = (last_rise[ch] != old) ? last_rise[ch] : cyc;
   endtask

   task automatic monitor();
      exp_t e;
      int   lo;
      int   hi;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_any = 1'b0;
         end else begin
            checks++;
            assert (anyp === prev_any) else begin
               errors++;
               $error("FAIL any_press @%0d: got %b expected %b",
                      cyc, anyp, prev_any);
            end
            prev_any = |pr;
            for (int c = 0; c < 3; c++)
               if (rs[c]) last_rise[c] = cyc;
            if ((rs | fl | pr) != 3'b000) begin
               checks++;
               assert (expq.size() != 0) else begin
                  errors++;
                  $error("FAIL event @%0d: got r=%b f=%b p=%b expected none",
                         cyc, rs, fl, pr);
               end
               if (expq.size() != 0) begin
                  e  = expq.pop_front();
                  lo = e.lo;
                  hi = e.hi;
                  if (e.rch >= 0) begin
                     lo += last_rise[e.rch];
                     hi += last_rise[e.rch];
                  end
                  checks++;
                  assert ({rs, fl, pr} === {e.rise, e.fall, e.press}) else begin
                     errors++;
                     $error("FAIL event_val @%0d: got r=%b f=%b p=%b expected r=%b f=%b p=%b",
                            cyc, rs, fl, pr, e.rise, e.fall, e.press);
                  end
                  checks++;
                  assert (cyc >= lo && cyc <= hi) else begin
                     errors++;
                     $error("FAIL event_time: got cycle %0d expected %0d..%0d",
                            cyc, lo, hi);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      int c0;
      int c1;
      int r;
      int old;

      fork
         monitor();
      join_none

      rst = 1'b1;
      din = 3'b000;
      ren = 3'b000;
      cycles(3);
      checks++;
      assert ({lvl, rs, fl, pr, anyp} === 13'b0) else begin
         errors++;
         $error("FAIL reset_state: got %b expected 0",
                {lvl, rs, fl, pr, anyp});
      end

      // 1: reset mid-run with all pins high, then a clean rise after release
      rst = 1'b0;
      c0  = cyc;
      din = 3'b111;
      push(3'b111, 3'b000, 3'b111, c0 + 11, c0 + 14, -1);
      drain(20, "first_rise");
      checks++;
      assert (lvl === 3'b111) else begin
         errors++;
         $error("FAIL level_high: got %b expected 111", lvl);
      end
      rst = 1'b1;
      #1;
      checks++;
      assert ({lvl, rs, fl, pr, anyp} === 13'b0) else begin
         errors++;
         $error("FAIL async_reset: got %b expected 0",
                {lvl, rs, fl, pr, anyp});
      end
      cycles(2);
      rst = 1'b0;
      c0  = cyc;
      push(3'b111, 3'b000, 3'b111, c0 + 11, c0 + 14, -1);
      drain(20, "rise_after_reset");
      c1  = cyc;
      din = 3'b000;
      push(3'b000, 3'b111, 3'b000, c1 + 11, c1 + 14, -1);
      drain(20, "fall_all");

      // 2: sub-tick glitches on channel 0
      for (int k = 0; k < 8; k++) begin
         din[0] = 1'b1;
         cycles(3);
         din[0] = 1'b0;
         cycles(3);
      end
      cycles(16);
      checks++;
      assert (lvl[0] === 1'b0) else begin
         errors++;
         $error("FAIL glitch_level: got %b expected 0", lvl[0]);
      end

      // 3: clean press/release on channel 1 without repeat
      c0     = cyc;
      din[1] = 1'b1;
      push(3'b010, 3'b000, 3'b010, c0 + 11, c0 + 14, -1);
      cycles(40);
      checks++;
      assert (lvl === 3'b010) else begin
         errors++;
         $error("FAIL hold_level: got %b expected 010", lvl);
      end
      c1     = cyc;
      din[1] = 1'b0;
      push(3'b000, 3'b010, 3'b000, c1 + 11, c1 + 14, -1);
      drain(20, "ch1_release");

      // 4: auto-repeat on channel 2, held 60 cycles past the rise
      ren    = 3'b100;
      old    = last_rise[2];
      c0     = cyc;
      din[2] = 1'b1;
      push(3'b100, 3'b000, 3'b100, c0 + 11, c0 + 14, -1);
      for (int k = 0; k < 7; k++)
         push(3'b000, 3'b000, 3'b100, 20 + 8 * k, 20 + 8 * k, 2);
      wait_rise(2, old, r);
      tick_to(r + 60);
      c1     = cyc;
      din[2] = 1'b0;
      push(3'b000, 3'b100, 3'b000, c1 + 11, c1 + 14, -1);
      drain(30, "repeat_release");

      // 5: drop rpt_en one cycle before the first periodic repeat
      old    = last_rise[2];
      c0     = cyc;
      din[2] = 1'b1;
      push(3'b100, 3'b000, 3'b100, c0 + 11, c0 + 14, -1);
      push(3'b000, 3'b000, 3'b100, 20, 20, 2);
      wait_rise(2, old, r);
      tick_to(r + 27);
      ren[2] = 1'b0;
      tick_to(r + 40);
      ren[2] = 1'b1;
      tick_to(r + 70);
      checks++;
      assert (expq.size() == 0 && lvl[2] === 1'b1) else begin
         errors++;
         $error("FAIL abort_state: got q=%0d lvl=%b expected q=0 lvl=1",
                expq.size(), lvl[2]);
      end
      c1     = cyc;
      din[2] = 1'b0;
      push(3'b000, 3'b100, 3'b000, c1 + 11, c1 + 14, -1);
      drain(20, "abort_release");

      // 6: coincident edges on channels 0 and 2
      ren = 3'b000;
      c0  = cyc;
      din = 3'b101;
      push(3'b101, 3'b000, 3'b101, c0 + 11, c0 + 14, -1);
      drain(20, "concurrent_rise");
      cycles(2);
      c1  = cyc;
      din = 3'b000;
      push(3'b000, 3'b101, 3'b000, c1 + 11, c1 + 14, -1);
      drain(20, "concurrent_fall");
      cycles(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
